axi_mem_responder: RTL

- AXI4 subordinate (responder) terminating the dcache refill/writeback port (`ariane_axi::req_t`/`resp_t`) or its bypass port.
- Services one burst at a time from an internal word-addressed SRAM of 64-bit words.
- Used as the memory-side endpoint in cache subsystem benches and as a small on-chip scratch memory behind the data/bypass AXI ports.

---
 rtl/axi_mem_responder.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/axi_mem_responder.sv
// AXI4 responder over a 64-bit word SRAM, one burst at a time; first R beat ReadLatency+2 cycles after AR, B one cycle after last W.
// R beats are held in an output register while r_ready is low; AW/AR/W are refused outside their states.
package ariane_axi;
  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
  } aw_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
  } ar_chan_t;

  typedef struct packed {
    logic [63:0] data;
    logic [7:0]  strb;
    logic        last;
  } w_chan_t;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [3:0]  id;
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_mem_responder #(
  parameter logic [63:0] BaseAddr    = 64'h8000_0000,
  parameter int unsigned NumWords    = 1024,
  parameter int unsigned ReadLatency = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  ariane_axi::req_t  axi_req_i,
  output ariane_axi::resp_t axi_resp_o,
  output logic              busy_o
);
  localparam int unsigned IdxW    = $clog2(NumWords);
  localparam logic [63:0] EndAddr = BaseAddr + 64'(NumWords) * 64'd8;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;
  localparam logic [1:0]  RespDecErr = 2'b11;
  localparam logic [1:0]  BurstFixed = 2'b00;
  localparam logic [1:0]  BurstWrap  = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DATA, WR_DATA, WR_RESP} state_e;
  state_e state_q, state_d;

  logic [3:0]  id_q, id_d;
  logic [63:0] addr_q, addr_d;
  logic [7:0]  len_q, len_d, cnt_q, cnt_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  burst_q, burst_d, resp_q, resp_d;
  logic [3:0]  lat_q, lat_d;
  logic        rd_pend_q, rd_pend_d, werr_q, werr_d;
  logic        r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [63:0] r_data_q, r_data_d;

  logic [63:0] mem_q [NumWords];

  logic            aw_rdy, ar_rdy, aw_hs, ar_hs, w_hs, r_hs, rd_issue, last_beat;
  logic [63:0]     offset, next_addr;
  logic [IdxW-1:0] idx;
  logic            unused_fields;

  function automatic logic [1:0] decode(input logic [63:0] a, input logic [2:0] s,
                                        input logic [1:0] b);
    if (a < BaseAddr || a >= EndAddr) return RespDecErr;
    if (b == BurstWrap || s > 3'd3)   return RespSlvErr;
    return RespOkay;
  endfunction

  assign aw_rdy    = (state_q == IDLE) && !rst_i;
  assign ar_rdy    = aw_rdy && !axi_req_i.aw_valid;
  assign aw_hs     = aw_rdy && axi_req_i.aw_valid;
  assign ar_hs     = ar_rdy && axi_req_i.ar_valid;
  assign w_hs      = (state_q == WR_DATA) && axi_req_i.w_valid;
  assign r_hs      = r_valid_q && axi_req_i.r_ready;
  // A read is issued only when the output register is free or draining this cycle.
  assign rd_issue  = (state_q == RD_DATA) && rd_pend_q && (!r_valid_q || axi_req_i.r_ready);
  assign last_beat = (cnt_q == len_q);
  assign offset    = addr_q - BaseAddr;
  assign idx       = offset[IdxW+2:3];
  assign next_addr = (burst_q == BurstFixed) ? addr_q : addr_q + (64'd1 << size_q);

  assign unused_fields = ^{axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
                           axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.atop,
                           axi_req_i.ar.lock, axi_req_i.ar.cache, axi_req_i.ar.prot,
                           axi_req_i.ar.qos, axi_req_i.ar.region,
                           offset[63:IdxW+3], offset[2:0]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      resp_q    <= '0;
      lat_q     <= '0;
      rd_pend_q <= 1'b0;
      werr_q    <= 1'b0;
      r_valid_q <= 1'b0;
      r_last_q  <= 1'b0;
      r_data_q  <= '0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      size_q    <= size_d;
      burst_q   <= burst_d;
      resp_q    <= resp_d;
      lat_q     <= lat_d;
      rd_pend_q <= rd_pend_d;
      werr_q    <= werr_d;
      r_valid_q <= r_valid_d;
      r_last_q  <= r_last_d;
      r_data_q  <= r_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_hs && resp_q == RespOkay) begin
      for (int b = 0; b < 8; b++) begin
        if (axi_req_i.w.strb[b]) mem_q[idx][8*b +: 8] <= axi_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (aw_hs)      state_d = WR_DATA;
        else if (ar_hs) state_d = (ReadLatency > 0) ? RD_WAIT : RD_DATA;
      end
      RD_WAIT: if (lat_q == 4'(ReadLatency - 1)) state_d = RD_DATA;
      RD_DATA: if (r_hs && r_last_q) state_d = IDLE;
      WR_DATA: if (w_hs && last_beat) state_d = WR_RESP;
      WR_RESP: if (axi_req_i.b_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    size_d    = size_q;
    burst_d   = burst_q;
    resp_d    = resp_q;
    lat_d     = lat_q;
    rd_pend_d = rd_pend_q;
    werr_d    = werr_q;
    r_valid_d = r_valid_q;
    r_last_d  = r_last_q;
    r_data_d  = r_data_q;
    if (aw_hs) begin
      id_d    = axi_req_i.aw.id;
      addr_d  = axi_req_i.aw.addr;
      len_d   = axi_req_i.aw.len;
      size_d  = axi_req_i.aw.size;
      burst_d = axi_req_i.aw.burst;
      resp_d  = decode(axi_req_i.aw.addr, axi_req_i.aw.size, axi_req_i.aw.burst);
      cnt_d   = '0;
      werr_d  = 1'b0;
    end else if (ar_hs) begin
      id_d      = axi_req_i.ar.id;
      addr_d    = axi_req_i.ar.addr;
      len_d     = axi_req_i.ar.len;
      size_d    = axi_req_i.ar.size;
      burst_d   = axi_req_i.ar.burst;
      resp_d    = decode(axi_req_i.ar.addr, axi_req_i.ar.size, axi_req_i.ar.burst);
      cnt_d     = '0;
      lat_d     = '0;
      rd_pend_d = 1'b1;
    end
    if (state_q == RD_WAIT) lat_d = lat_q + 4'd1;
    if (rd_issue) begin
      r_valid_d = 1'b1;
      r_last_d  = last_beat;
      r_data_d  = (resp_q == RespOkay) ? mem_q[idx] : '0;
      addr_d    = next_addr;
      if (last_beat) rd_pend_d = 1'b0;
      else           cnt_d     = cnt_q + 8'd1;
    end else if (r_hs) begin
      r_valid_d = 1'b0;
    end
    // Termination follows len; a disagreeing w_last only taints the response.
    if (w_hs) begin
      werr_d = werr_q | (axi_req_i.w.last != last_beat);
      addr_d = next_addr;
      cnt_d  = cnt_q + 8'd1;
    end
  end

  always_comb begin
    axi_resp_o          = '0;
    axi_resp_o.aw_ready = aw_rdy;
    axi_resp_o.ar_ready = ar_rdy;
    axi_resp_o.w_ready  = (state_q == WR_DATA);
    axi_resp_o.b_valid  = (state_q == WR_RESP);
    axi_resp_o.b.id     = id_q;
    axi_resp_o.b.resp   = (resp_q != RespOkay) ? resp_q : (werr_q ? RespSlvErr : RespOkay);
    axi_resp_o.r_valid  = r_valid_q;
    axi_resp_o.r.id     = id_q;
    axi_resp_o.r.data   = r_data_q;
    axi_resp_o.r.resp   = resp_q;
    axi_resp_o.r.last   = r_last_q;
    busy_o              = (state_q != IDLE);
  end
endmodule
